prio_seq_enc: RTL and testbench
===============================

Name: prio_seq_enc

Overview:
- Parametrised, sequential successor of the 8-to-3 priority encoder.
- Accepts an N-bit request vector over a valid/ready handshake and emits one set-bit index per output handshake until every set bit is served.
- Two selection modes: fixed priority (highest index first) and round-robin (rotating pointer).
- Sits between interrupt/request sources and a single-consumer dispatcher in npc.

Parameters:
- N, 8, number of request bits; any value >= 2, not restricted to powers of 2.
- W, $clog2(N), index width (derived; not overridden).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  enable; when 0, no new vector is accepted (in_ready=0); a vector in progress continues
- mode_rr  in  1  0 = fixed priority, 1 = round-robin; sampled only at accept
- in_valid  in  1  request vector valid
- in_req  in  N  request vector
- in_ready  out  1  block can accept a vector
- out_valid  out  1  out_idx valid
- out_idx  out  W  index of the bit currently being served
- out_last  out  1  out_idx is the final set bit of the current vector
- out_ready  in  1  consumer accepts out_idx

Behaviour:
- Reset (synchronous, priority over all else, including mid-vector):
  - state=IDLE, pending=0, ptr=0, mode_q=0.
  - Outputs: out_valid=0, out_idx=0, out_last=0, in_ready=0 during the reset cycle.
  - Any partially served vector is discarded.
- States:
  - IDLE:
    - in_ready = en.
    - Accept = in_valid & in_ready.
    - Accept with in_req != 0: pending<=in_req, mode_q<=mode_rr, go to BUSY.
    - Accept with in_req == 0: vector consumed, no output, stay IDLE.
  - BUSY:
    - in_ready=0; in_valid is ignored.
    - out_valid=1.
    - out_idx=pick(pending, ptr, mode_q).
    - out_last=1 iff exactly one bit of pending is set.
- pick:
  - Fixed mode: highest set index in pending.
  - RR mode: first set index scanning upward from ptr, wrapping N-1 -> 0.
  - For N not a power of 2, the wrap is mod N.
- Output handshake (out_valid & out_ready):
  - Clear the served bit from pending.
  - In RR mode: ptr <= (out_idx+1) mod N. ptr is unchanged in fixed mode.
  - If out_last: go to IDLE.
- Latency:
  - First out_valid appears the cycle after accept.
  - Each subsequent index follows one cycle after the previous handshake.
  - A vector with k set bits therefore completes in k cycles under continuous out_ready.
- Back-to-back: the next vector can be accepted in the cycle after the final handshake (one-cycle IDLE bubble).
- Backpressure: while out_valid & !out_ready, out_idx, out_last and pending stay stable.
- IDLE outputs: out_valid=0, out_idx=0, out_last=0.
- Pointer lifetime: ptr persists across vectors and across mode changes; it is cleared only by rst.
- Mode changes: a change of mode_rr during BUSY has no effect until the next accept.
- en: deasserting en during BUSY does not stall output.

Decomposition:
- Package prio_seq_pkg:
  - Function for rotated find-first-set.
  - Mode constants MODE_FIXED=0, MODE_RR=1.
  - State enum IDLE/BUSY.
- Sub-module prio_pick (combinational):
  - Inputs: vec[N], start[W], mode.
  - Outputs: idx[W], found, onehot_last.
  - Shared with later arbiters.

Test Plan:
- Fixed mode, N=8, accept in_req=8'b1010_0101 with out_ready=1 -> out_idx 7,5,2,0 on consecutive cycles; out_last=1 only with 0; in_ready=1 on the following cycle.
- RR mode from reset (ptr=0):
  - Accept 8'h24 -> idx 2, 5 (ptr becomes 6).
  - Then accept 8'b1100_0011 -> idx 6,7,0,1 (wrap); final ptr=2.
- Backpressure: during 8'h81 fixed mode, hold out_ready=0 for 3 cycles -> out_idx=7 stable, out_valid=1, no bit cleared; release -> 7 then 0.
- Zero vector and blocking:
  - in_req=0 with in_valid=1 in IDLE -> consumed, out_valid stays 0, in_ready stays 1.
  - in_valid=1 during BUSY -> ignored; pending unchanged.
- Enable and mode latching:
  - en=0 in IDLE -> in_ready=0, in_valid not accepted.
  - en dropped mid-BUSY -> remaining indices still emitted.
  - mode_rr toggled mid-BUSY -> selection order unchanged.
- Reset mid-vector: assert rst after the first index of 8'hFF -> next cycle out_valid=0, ptr=0, state IDLE; a new vector 8'h01 yields idx 0 with out_last=1.

Source files
------------

// File: rtl/prio_seq_enc_pkg.sv
// Shared types, mode constants and the rotated find-first-set helper for the
// sequential priority encoder and later arbiters.
package prio_seq_pkg;

  // Largest request width the rotated search supports.
  localparam int MAX_N = 256;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // First set bit of vec[n-1:0] scanning upward from start and wrapping n-1 -> 0.
  // Returns -1 when no bit is set. start must be below n.
  function automatic int rot_ffs(input logic [MAX_N-1:0] vec, input int n, input int start);
    int r;
    int j;
    r = -1;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      j = start + k;
      if (j >= n) j = j - n;
      if ((k < n) && (j >= 0) && (j < MAX_N) && vec[j]) r = j;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_seq_enc_pick.sv
// Combinational selector: highest set index (fixed) or first set index at or
// above a rotating start (round-robin), plus a flag for a single remaining bit.
module prio_pick
  import prio_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         onehot_last
);

  logic [MAX_N-1:0] vec_ext;
  logic [W-1:0]     hi_idx;

  // Select the index to serve and classify the remaining request set.
  always_comb begin
    vec_ext          = '0;
    vec_ext[N-1:0]   = vec;
    hi_idx           = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) hi_idx = W'(i);
    end
    found       = |vec;
    onehot_last = found && ((vec & (vec - 1'b1)) == '0);
    if (mode == MODE_RR) idx = W'(rot_ffs(vec_ext, N, int'(start)));
    else                 idx = hi_idx;
  end

endmodule

// File: rtl/prio_seq_enc.sv
// Sequential priority encoder: accepts a request vector, then emits one set-bit
// index per output handshake in fixed or round-robin order until all are served.
module prio_seq_enc
  import prio_seq_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode_rr,
  input  logic         in_valid,
  input  logic [N-1:0] in_req,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  input  logic         out_ready
);

  state_t       state;
  logic [N-1:0] pending;
  logic [W-1:0] ptr;
  logic         mode_q;

  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic         pick_last;
  logic         busy_out;
  logic         hs;
  logic [N-1:0] served_mask;
  logic [W-1:0] ptr_next;

  prio_pick #(.N(N), .W(W)) u_pick (
    .vec         (pending),
    .start       (ptr),
    .mode        (mode_q),
    .idx         (pick_idx),
    .found       (pick_found),
    .onehot_last (pick_last)
  );

  // Outputs come straight from registered state; reset forces them quiet in its own cycle.
  assign busy_out    = (state == BUSY) && !rst && pick_found;
  assign in_ready    = (state == IDLE) && en && !rst;
  assign out_valid   = busy_out;
  assign out_idx     = busy_out ? pick_idx : '0;
  assign out_last    = busy_out && pick_last;
  assign hs          = out_valid && out_ready;
  assign served_mask = {{(N-1){1'b0}}, 1'b1} << pick_idx;
  assign ptr_next    = (pick_idx == W'(N - 1)) ? '0 : pick_idx + 1'b1;

  // Accept vectors in IDLE, retire one index per handshake in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      ptr     <= '0;
      mode_q  <= MODE_FIXED;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready && (in_req != '0)) begin
            pending <= in_req;
            mode_q  <= mode_rr;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            pending <= pending & ~served_mask;
            if (mode_q == MODE_RR) ptr <= ptr_next;
            if (pick_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_seq_enc.sv
// Bench for prio_seq_enc: behavioural model checked every cycle, directed
// scenarios with literal index sequences, then randomized traffic.
module tb_prio_seq_enc;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         mode_rr = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_req = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Model state: what is still owed, the rotating pointer, latched mode.
  bit         m_busy = 1'b0;
  bit [N-1:0] m_pend = '0;
  int         m_ptr  = 0;
  bit         m_mode = 1'b0;

  int served[$];
  bit served_last[$];
  int exp_q[$];

  prio_seq_enc #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode_rr   (mode_rr),
    .in_valid  (in_valid),
    .in_req    (in_req),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Which bit is owed next, by the stated rules.
  function automatic int m_pick();
    if (!m_mode) begin
      for (int k = N - 1; k >= 0; k--) if (m_pend[k]) return k;
    end else begin
      for (int k = 0; k < N; k++) if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return 0;
  endfunction

  // Model advance on each rising edge from the applied inputs.
  always @(posedge clk) begin
    int idx;
    if (rst) begin
      m_busy = 0; m_pend = '0; m_ptr = 0; m_mode = 0;
    end else if (!m_busy) begin
      if (in_valid && en && (in_req != '0)) begin
        m_pend = in_req; m_mode = mode_rr; m_busy = 1;
      end
    end else if (out_ready) begin
      idx = m_pick();
      m_pend[idx] = 1'b0;
      if (m_mode) m_ptr = (idx + 1) % N;
      if (m_pend == '0) m_busy = 0;
    end
  end

  // Per-cycle compare of all outputs against the model, on the falling edge.
  always @(negedge clk) begin
    bit e_valid;
    if (chk_on) begin
      e_valid = m_busy && !rst;
      chk("out_valid", int'(out_valid), int'(e_valid));
      chk("out_idx",   int'(out_idx),   e_valid ? m_pick() : 0);
      chk("out_last",  int'(out_last),  int'(e_valid && ($countones(m_pend) == 1)));
      chk("in_ready",  int'(in_ready),  int'(!m_busy && en && !rst));
      if (out_valid && out_ready) begin
        served.push_back(int'(out_idx));
        served_last.push_back(out_last);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] req, input logic m);
    for (int t = 0; t < 40 && !in_ready; t++) cyc();
    in_valid = 1'b1; in_req = req; mode_rr = m;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit to;
    to = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (!out_valid) begin to = 1'b0; break; end
      cyc();
    end
    chk("drain_timeout", int'(to), 0);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_count"}, served.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(name, (i < served.size()) ? served[i] : -1, exp_q[i]);
    served.delete();
    served_last.delete();
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", int'(in_ready), 1);

    // Fixed priority, continuous ready.
    served.delete(); served_last.delete();
    send(8'b1010_0101, 1'b0);
    drain();
    chk("fixed_last_flag", int'(served_last[3]), 1);
    chk("fixed_nonlast_flag", int'(served_last[0] | served_last[1] | served_last[2]), 0);
    exp_q = '{7, 5, 2, 0}; check_seq("fixed_a5");
    chk("fixed_in_ready_after", int'(in_ready), 1);

    // Round-robin from pointer 0, then wrap.
    send(8'h24, 1'b1); drain();
    exp_q = '{2, 5}; check_seq("rr_24");
    chk("rr_ptr_after_24", m_ptr, 6);
    send(8'b1100_0011, 1'b1); drain();
    exp_q = '{6, 7, 0, 1}; check_seq("rr_c3");
    chk("rr_ptr_after_c3", m_ptr, 2);
    send(8'h07, 1'b1); drain();
    exp_q = '{2, 0, 1}; check_seq("rr_07");

    // Backpressure holds the current index.
    out_ready = 1'b0;
    send(8'h81, 1'b0);
    cyc(); cyc(); cyc();
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_idx", int'(out_idx), 7);
    chk("bp_served", served.size(), 0);
    out_ready = 1'b1;
    drain();
    exp_q = '{7, 0}; check_seq("bp_81");

    // Zero vector is consumed silently.
    send(8'h00, 1'b0);
    chk("zero_out_valid", int'(out_valid), 0);
    chk("zero_in_ready", int'(in_ready), 1);

    // in_valid during BUSY is ignored.
    send(8'h0F, 1'b0);
    in_valid = 1'b1; in_req = 8'hFF;
    drain();
    in_valid = 1'b0;
    exp_q = '{3, 2, 1, 0}; check_seq("busy_ignore");

    // en low in IDLE blocks acceptance.
    en = 1'b0; in_valid = 1'b1; in_req = 8'h10;
    cyc(); cyc();
    chk("en0_in_ready", int'(in_ready), 0);
    chk("en0_out_valid", int'(out_valid), 0);
    in_valid = 1'b0; en = 1'b1;

    // en dropped and mode toggled mid-vector.
    send(8'h92, 1'b0);
    cyc();
    en = 1'b0; mode_rr = 1'b1;
    drain();
    en = 1'b1;
    exp_q = '{7, 4, 1}; check_seq("en_mode_mid");

    // Reset mid-vector.
    send(8'hFF, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0);
    exp_q = '{7}; check_seq("rst_mid");
    send(8'h81, 1'b1); drain();
    exp_q = '{0, 7}; check_seq("rr_after_rst");
    send(8'h01, 1'b0); drain();
    chk("single_last", int'(served_last[0]), 1);
    exp_q = '{0}; check_seq("single_01");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       in_req = '0;
        1:       in_req = N'(1) << $urandom_range(0, N - 1);
        default: in_req = N'($urandom);
      endcase
      in_valid  = 1'($urandom_range(0, 1));
      mode_rr   = 1'($urandom_range(0, 1));
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 99) == 0);
      cyc();
      served.delete(); served_last.delete();
    end
    rst = 1'b0; in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
    cyc();
    drain();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
